// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider and enable-tick generator.
//
// A WIDTH-bit counter runs 0..div_cur-1 while enable is high. clk_out is a
// registered compare of the counter against duty_cur. tick is a 1-cycle strobe
// coincident with the counter returning to 0. New divisor/high-time values are
// captured into shadow registers through a load handshake. They take effect
// only at a period boundary, or on the next cycle when the divider is idle, so
// a period is never cut short or stretched.
//
// Optional feature: define CLKDIV_PHASE_EN to add a phase_in port. The port
// value is captured with load, and the counter starts from that value when the
// new configuration is applied.
//
// Ports:
//   clock    in   sole clock, rising edge
//   reset    in   asynchronous active-high reset
//   enable   in   run divider (0 holds the counter at 0)
//   div_in   in   requested divisor, sampled on load
//   duty_in  in   requested high-time, sampled on load
//   phase_in in   requested start count (CLKDIV_PHASE_EN only)
//   load     in   request capture of div_in/duty_in
//   load_ack out  1-cycle pulse when a captured configuration becomes active
//   cfg_err  out  1-cycle pulse when a load is rejected
//   pending  out  a configuration is captured and awaiting application
//   clk_out  out  divided clock, from a flop
//   tick     out  1-cycle strobe once per period
module clk_div_prog #(
  parameter int unsigned WIDTH        = 14,
  parameter int unsigned DIV_DEFAULT  = 2000,
  parameter int unsigned DUTY_DEFAULT = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] duty_in,
`ifdef CLKDIV_PHASE_EN
  input  logic [WIDTH-1:0] phase_in,
`endif
  input  logic             load,
  output logic             load_ack,
  output logic             cfg_err,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DUTY_DEFAULT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] duty_cur_q, duty_cur_d;
  logic [WIDTH-1:0] div_sh_q, div_sh_d;
  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             load_ack_q, load_ack_d;
  logic             cfg_err_q, cfg_err_d;
`ifdef CLKDIV_PHASE_EN
  logic [WIDTH-1:0] phase_sh_q, phase_sh_d;
`endif

  logic             boundary_c;
  logic             apply_c;
  logic             load_take_c;
  logic             load_valid_c;
  logic [WIDTH-1:0] start_cnt_c;

  // Period boundary: last count of the current period while running.
  // div_cur is always >= 2, so div_cur-1 never underflows.
  assign boundary_c = enable && (cnt_q == (div_cur_q - WIDTH'(1)));

  // A pending configuration is applied at the boundary, or at once when idle.
  assign apply_c = pending_q && (boundary_c || !enable);

  // Loads are only looked at while no configuration is waiting.
  assign load_take_c = load && !pending_q;

`ifdef CLKDIV_PHASE_EN
  assign load_valid_c = (div_in >= WIDTH'(2)) && (duty_in <= div_in) &&
                        (phase_in < div_in);
  // The phase offset only matters while running; an idle divider stays at 0.
  assign start_cnt_c  = enable ? phase_sh_q : '0;
`else
  assign load_valid_c = (div_in >= WIDTH'(2)) && (duty_in <= div_in);
  assign start_cnt_c  = '0;
`endif

  // Next-state and output computation.
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    duty_cur_d = duty_cur_q;
    div_sh_d   = div_sh_q;
    duty_sh_d  = duty_sh_q;
    pending_d  = pending_q;
    clk_out_d  = 1'b0;
    tick_d     = 1'b0;
    load_ack_d = 1'b0;
    cfg_err_d  = 1'b0;
`ifdef CLKDIV_PHASE_EN
    phase_sh_d = phase_sh_q;
`endif

    // Counter and registered outputs.
    if (enable) begin
      clk_out_d = (cnt_q < duty_cur_q);
      tick_d    = boundary_c;
      cnt_d     = boundary_c ? '0 : cnt_q + WIDTH'(1);
    end else begin
      cnt_d = '0;
    end

    // Configuration switch-over at the period edge.
    if (apply_c) begin
      div_cur_d  = div_sh_q;
      duty_cur_d = duty_sh_q;
      cnt_d      = start_cnt_c;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end

    // Load capture or rejection.
    if (load_take_c) begin
      if (load_valid_c) begin
        div_sh_d  = div_in;
        duty_sh_d = duty_in;
        pending_d = 1'b1;
`ifdef CLKDIV_PHASE_EN
        phase_sh_d = phase_in;
`endif
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_cur_q  <= DIV_RST;
      duty_cur_q <= DUTY_RST;
      div_sh_q   <= DIV_RST;
      duty_sh_q  <= DUTY_RST;
      pending_q  <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      load_ack_q <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef CLKDIV_PHASE_EN
      phase_sh_q <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      duty_cur_q <= duty_cur_d;
      div_sh_q   <= div_sh_d;
      duty_sh_q  <= duty_sh_d;
      pending_q  <= pending_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      load_ack_q <= load_ack_d;
      cfg_err_q  <= cfg_err_d;
`ifdef CLKDIV_PHASE_EN
      phase_sh_q <= phase_sh_d;
`endif
    end
  end

  assign load_ack = load_ack_q;
  assign cfg_err  = cfg_err_q;
  assign pending  = pending_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog (default build, DIV_DEFAULT=4, DUTY_DEFAULT=2).
// A behavioural model tracks period position, active and shadow settings.
// Every cycle, all five outputs are compared against that model.
module tb_clk_div_prog;

  localparam int unsigned WIDTH = 14;
  localparam int DIV_DEF  = 4;
  localparam int DUTY_DEF = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] div_in;
  logic [WIDTH-1:0] duty_in;
  logic             load;
  logic             load_ack;
  logic             cfg_err;
  logic             pending;
  logic             clk_out;
  logic             tick;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model state: position in period, active and shadow settings.
  int m_pos, m_div, m_duty, m_sdiv, m_sduty;
  bit m_pend;
  // Expected outputs.
  bit e_clk, e_tick, e_ack, e_err, e_pend;

  clk_div_prog #(
    .WIDTH       (WIDTH),
    .DIV_DEFAULT (DIV_DEF),
    .DUTY_DEFAULT(DUTY_DEF)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .div_in  (div_in),
    .duty_in (duty_in),
    .load    (load),
    .load_ack(load_ack),
    .cfg_err (cfg_err),
    .pending (pending),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_pos = 0; m_div = DIV_DEF; m_duty = DUTY_DEF;
    m_sdiv = DIV_DEF; m_sduty = DUTY_DEF; m_pend = 1'b0;
    e_clk = 0; e_tick = 0; e_ack = 0; e_err = 0; e_pend = 0;
  endtask

  // One clock of the specified behaviour, using integer period arithmetic.
  task automatic model_step(input bit en, input bit ld, input int d, input int du);
    bit last;
    bit valid;
    bit take;
    last   = en && (m_pos == m_div - 1);
    valid  = (d >= 2) && (du <= d);
    take   = ld && !m_pend;
    e_clk  = en && (m_pos < m_duty);
    e_tick = last;
    e_ack  = m_pend && (last || !en);
    e_err  = take && !valid;
    m_pos  = en ? (m_pos + 1) % m_div : 0;
    if (e_ack) begin
      m_div = m_sdiv; m_duty = m_sduty; m_pend = 1'b0; m_pos = 0;
    end
    if (take && valid) begin
      m_sdiv = d; m_sduty = du; m_pend = 1'b1;
    end
    e_pend = m_pend;
  endtask

  task automatic check_outs(input string tag);
    total_cnt++;
    assert (clk_out === e_clk) pass_cnt++;
    else $error("FAIL %s clk_out got %b exp %b", tag, clk_out, e_clk);
    total_cnt++;
    assert (tick === e_tick) pass_cnt++;
    else $error("FAIL %s tick got %b exp %b", tag, tick, e_tick);
    total_cnt++;
    assert (load_ack === e_ack) pass_cnt++;
    else $error("FAIL %s load_ack got %b exp %b", tag, load_ack, e_ack);
    total_cnt++;
    assert (cfg_err === e_err) pass_cnt++;
    else $error("FAIL %s cfg_err got %b exp %b", tag, cfg_err, e_err);
    total_cnt++;
    assert (pending === e_pend) pass_cnt++;
    else $error("FAIL %s pending got %b exp %b", tag, pending, e_pend);
  endtask

  task automatic cycle(input string tag, input bit en, input bit ld,
                       input int d, input int du);
    enable  = en;
    load    = ld;
    div_in  = WIDTH'(d);
    duty_in = WIDTH'(du);
    @(posedge clock);
    model_step(en, ld, d, du);
    #1;
    check_outs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; div_in = '0; duty_in = '0;
    model_reset();
    #12;
    check_outs("reset");
    reset = 1'b0;

    // Default divide-by-4, 2 high.
    run("default", 12);

    // Valid load 6/3 issued at counter==1.
    for (int i = 0; i < 8 && m_pos != 1; i++) run("align1", 1);
    cycle("load63", 1'b1, 1'b1, 6, 3);
    run("apply63", 14);

    // Return to 4/2, then invalid loads.
    cycle("load42", 1'b1, 1'b1, 4, 2);
    run("apply42", 8);
    cycle("bad_div1", 1'b1, 1'b1, 1, 0);
    run("after_bad1", 2);
    cycle("bad_duty", 1'b1, 1'b1, 5, 6);
    run("after_bad2", 6);

    // Load while pending is ignored.
    for (int i = 0; i < 8 && m_pos != 0; i++) run("align0", 1);
    cycle("load8", 1'b1, 1'b1, 8, 4);
    cycle("load10_ign", 1'b1, 1'b1, 10, 5);
    run("apply8", 18);

    // Duty extremes.
    cycle("duty0", 1'b1, 1'b1, 4, 0);
    run("const0", 14);
    cycle("duty4", 1'b1, 1'b1, 4, 4);
    run("const1", 14);
    cycle("duty2", 1'b1, 1'b1, 4, 2);
    run("back42", 8);

    // Drop enable mid-period, then re-enable.
    for (int i = 0; i < 8 && m_pos != 1; i++) run("align_en", 1);
    cycle("en_off", 1'b0, 1'b0, 0, 0);
    cycle("en_off2", 1'b0, 1'b0, 0, 0);
    run("reenable", 9);

    // Load while idle applies on the next cycle.
    cycle("idle_load", 1'b0, 1'b1, 3, 1);
    cycle("idle_apply", 1'b0, 1'b0, 0, 0);
    run("run31", 9);

    // Reset while a configuration is pending: discarded silently.
    cycle("pre_rst_load", 1'b1, 1'b1, 7, 3);
    reset = 1'b1;
    #1;
    model_reset();
    check_outs("mid_reset");
    #2;
    reset = 1'b0;
    run("post_reset", 12);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cycle("random", ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
